move_flip_controller: RTL and testbench
=======================================

Name: move_flip_controller

Overview:
- Sequences the board-memory datapath for one Othello move.
- On request from the main game controller, it checks that the target cell is empty and scans all 8 directions from it. It flips every bracketed opponent disc, places the mover's disc, and returns done/ack.
- It sits between the main game controller (new_move, player, nm_done, ack) and the single-port 64-cell board RAM.

Parameters:
- BOARD_BITS, 3, log2 of board side; side = 2^BOARD_BITS, address width = 2*BOARD_BITS.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- new_move  in  1  level request; held high by the main controller until nm_done is seen.
- player  in  1  0 = black (cell 2'b01), 1 = white (cell 2'b10); latched on accept.
- move_x  in  BOARD_BITS  target column; latched on accept.
- move_y  in  BOARD_BITS  target row; latched on accept.
- mem_addr  out  2*BOARD_BITS  board address = {y,x}; registered.
- mem_we  out  1  write enable; registered.
- mem_wdata  out  2  write data; registered.
- mem_rdata  in  2  read data; valid the cycle after mem_addr is presented with mem_we=0.
- nm_done  out  1  one-cycle pulse when the move is finished.
- ack  out  1  move was legal; meaningful only while nm_done=1.
- flip_count  out  6  discs flipped by the last move; held until the next accept.

Behaviour:
- Reset (async, reset=0):
  - state IDLE.
  - mem_addr, mem_we, mem_wdata, nm_done, ack, flip_count all 0.
  - Latches cleared.
- Cell codes: 00 empty, 01 black, 10 white, 11 treated as empty (terminates a scan).
- Own colour = {player, ~player}; opponent = {~player, player}.
- Directions are processed in fixed order 0..7: N(0,-1), NE(+1,-1), E(+1,0), SE(+1,+1), S(0,+1), SW(-1,+1), W(-1,0), NW(-1,-1).
- Coordinates are computed one bit wider and signed. A cursor is off-board when any coordinate is <0 or >2^BOARD_BITS-1. There is no wrap-around.
- State machine:
  - IDLE: new_move=1 -> latch player/x/y; clear flip_count and run_cnt; -> RD_ORG.
  - RD_ORG: mem_addr=origin, mem_we=0 -> CHK_ORG.
  - CHK_ORG: mem_rdata!=00 -> FINISH, ack=0 (occupied). Otherwise dir=0 -> DIR_INIT.
  - DIR_INIT: cursor=origin+step(dir); run_cnt=0. Off-board -> NEXT_DIR, else -> SCAN_RD.
  - SCAN_RD: mem_addr=cursor -> SCAN_CHK.
  - SCAN_CHK:
    - rdata==opponent: run_cnt++, cursor+=step; off-board -> NEXT_DIR, else -> SCAN_RD.
    - rdata==own with run_cnt>0: cursor=origin+step -> FLIP.
    - Anything else -> NEXT_DIR.
  - FLIP: write own colour at cursor; flip_count++, cursor+=step, run_cnt--. When run_cnt reaches 0 -> NEXT_DIR. One write per cycle.
  - NEXT_DIR:
    - dir<7: dir++ -> DIR_INIT.
    - dir==7 and flip_count>0 -> PLACE.
    - Otherwise -> FINISH, ack=0.
  - PLACE: write own colour at origin -> FINISH, ack=1.
  - FINISH: nm_done=1 for exactly 1 cycle, ack valid -> RELEASE.
  - RELEASE: wait for new_move=0 -> IDLE. A new_move still high from the completed request is never re-accepted.
- Rays from one origin are disjoint, so flips in earlier directions never affect later scans.
- An illegal move performs zero writes.
- Latency:
  - Occupied origin: nm_done 3 cycles after accept.
  - Worst case bounded by 3 + 8*(1 + 2*(2^BOARD_BITS-1) + 1) + 18 + 1 cycles.
- Inputs player/move_x/move_y are ignored outside IDLE.
- Reset mid-operation: abort immediately. Writes already done remain in RAM; no nm_done is produced.
- mem_we is high only in FLIP and PLACE.

Test Plan:
- Standard opening: W at (3,3),(4,4); B at (4,3),(3,4). Black new_move at (3,2).
  - Expect: write addr 27 = 01, then addr 19 = 01.
  - Expect: nm_done pulse with ack=1, flip_count=1.
- Occupied target: player 0 at (3,3) -> no writes; nm_done 3 cycles after accept; ack=0; flip_count=0.
- No bracket: empty cell at (0,0) on opening board -> all 8 directions scanned; zero writes; ack=0.
- Multi-direction plus edge:
  - Board has white at (1,1),(2,2),(1,0),(0,1) and black at (3,3),(2,0),(0,2). Black plays (0,0).
  - Expect: flips at (1,0),(1,1),(2,2),(0,1) and place at (0,0).
  - Expect: flip_count=4, ack=1; no address outside the board is issued.
- Handshake: new_move held high 10 cycles after nm_done -> no second accept. Drop new_move, then re-raise -> a new accept occurs.
- Reset asserted during FLIP -> outputs 0 immediately. After release, a fresh request completes normally.

Source files
------------

// File: rtl/move_flip_controller_if.sv
// rtl/move_flip_controller_if.sv - board RAM port bundle between the move controller and the 64-cell RAM
interface move_flip_controller_if #(
  parameter int BOARD_BITS = 3
) ();
  logic [2*BOARD_BITS-1:0] mem_addr;
  logic                    mem_we;
  logic [1:0]              mem_wdata;
  logic [1:0]              mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/move_flip_controller.sv
// rtl/move_flip_controller.sv - validates one Othello move, flips bracketed discs and places the mover's disc
module move_flip_controller #(
  parameter int BOARD_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  new_move,
  input  logic                  player,
  input  logic [BOARD_BITS-1:0] move_x,
  input  logic [BOARD_BITS-1:0] move_y,
  output logic                  nm_done,
  output logic                  ack,
  output logic [5:0]            flip_count,
  move_flip_controller_if.master bus
);
  localparam int CW = BOARD_BITS + 1;
  localparam logic signed [CW-1:0] MAXC = CW'((1 << BOARD_BITS) - 1);

  typedef enum logic [3:0] {
    IDLE, RD_ORG, CHK_ORG, DIR_INIT, SCAN_RD, SCAN_CHK,
    FLIP, NEXT_DIR, PLACE, FINISH, RELEASE
  } state_t;

  state_t                 state;
  logic                   player_q;
  logic signed [CW-1:0]   ox, oy, cx, cy;
  logic [2:0]             dir;
  logic [BOARD_BITS-1:0]  run_cnt;

  function automatic logic signed [CW-1:0] step_x(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: step_x = CW'(1);
      3'd5, 3'd6, 3'd7: step_x = {CW{1'b1}};
      default:          step_x = '0;
    endcase
  endfunction

  function automatic logic signed [CW-1:0] step_y(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: step_y = {CW{1'b1}};
      3'd3, 3'd4, 3'd5: step_y = CW'(1);
      default:          step_y = '0;
    endcase
  endfunction

  // A wrapped +1 past the edge lands on a negative value, so the sign bit catches it too.
  function automatic logic off_board(input logic signed [CW-1:0] x, input logic signed [CW-1:0] y);
    off_board = x[CW-1] || y[CW-1] || (x > MAXC) || (y > MAXC);
  endfunction

  function automatic logic [2*BOARD_BITS-1:0] addr_of(input logic signed [CW-1:0] x,
                                                      input logic signed [CW-1:0] y);
    addr_of = {y[BOARD_BITS-1:0], x[BOARD_BITS-1:0]};
  endfunction

  logic signed [CW-1:0] sx, sy, ix, iy, nx, ny;
  logic [1:0]           own, opp;

  assign sx  = step_x(dir);
  assign sy  = step_y(dir);
  assign ix  = ox + sx;
  assign iy  = oy + sy;
  assign nx  = cx + sx;
  assign ny  = cy + sy;
  assign own = {player_q, ~player_q};
  assign opp = {~player_q, player_q};

  // Memory outputs are loaded on the edge entering a state, so each state presents its own address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= 2'b00;
      nm_done       <= 1'b0;
      ack           <= 1'b0;
      flip_count    <= '0;
      player_q      <= 1'b0;
      ox            <= '0;
      oy            <= '0;
      cx            <= '0;
      cy            <= '0;
      dir           <= '0;
      run_cnt       <= '0;
    end else begin
      nm_done <= 1'b0;
      case (state)
        IDLE: begin
          if (new_move) begin
            player_q     <= player;
            ox           <= {1'b0, move_x};
            oy           <= {1'b0, move_y};
            flip_count   <= '0;
            run_cnt      <= '0;
            ack          <= 1'b0;
            bus.mem_addr <= {move_y, move_x};
            state        <= RD_ORG;
          end
        end
        RD_ORG: state <= CHK_ORG;
        CHK_ORG: begin
          if (bus.mem_rdata != 2'b00) begin
            ack     <= 1'b0;
            nm_done <= 1'b1;
            state   <= FINISH;
          end else begin
            dir   <= '0;
            state <= DIR_INIT;
          end
        end
        DIR_INIT: begin
          cx      <= ix;
          cy      <= iy;
          run_cnt <= '0;
          if (off_board(ix, iy)) begin
            state <= NEXT_DIR;
          end else begin
            bus.mem_addr <= addr_of(ix, iy);
            state        <= SCAN_RD;
          end
        end
        SCAN_RD: state <= SCAN_CHK;
        SCAN_CHK: begin
          if (bus.mem_rdata == opp) begin
            run_cnt <= run_cnt + BOARD_BITS'(1);
            cx      <= nx;
            cy      <= ny;
            if (off_board(nx, ny)) begin
              state <= NEXT_DIR;
            end else begin
              bus.mem_addr <= addr_of(nx, ny);
              state        <= SCAN_RD;
            end
          end else if (bus.mem_rdata == own && run_cnt != '0) begin
            cx            <= ix;
            cy            <= iy;
            bus.mem_addr  <= addr_of(ix, iy);
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= own;
            state         <= FLIP;
          end else begin
            state <= NEXT_DIR;
          end
        end
        FLIP: begin
          flip_count <= flip_count + 6'd1;
          cx         <= nx;
          cy         <= ny;
          run_cnt    <= run_cnt - BOARD_BITS'(1);
          if (run_cnt == BOARD_BITS'(1)) begin
            bus.mem_we <= 1'b0;
            state      <= NEXT_DIR;
          end else begin
            bus.mem_addr <= addr_of(nx, ny);
          end
        end
        NEXT_DIR: begin
          if (dir != 3'd7) begin
            dir   <= dir + 3'd1;
            state <= DIR_INIT;
          end else if (flip_count != '0) begin
            bus.mem_addr  <= addr_of(ox, oy);
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= own;
            state         <= PLACE;
          end else begin
            ack     <= 1'b0;
            nm_done <= 1'b1;
            state   <= FINISH;
          end
        end
        PLACE: begin
          bus.mem_we <= 1'b0;
          ack        <= 1'b1;
          nm_done    <= 1'b1;
          state      <= FINISH;
        end
        FINISH:  state <= RELEASE;
        RELEASE: if (!new_move) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_flip_controller.sv
// tb/tb_move_flip_controller.sv - self-checking bench with a board-level Othello reference model
module tb_move_flip_controller;
  localparam int DX [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  localparam int DY [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       new_move = 1'b0;
  logic       player = 1'b0;
  logic [2:0] move_x = '0;
  logic [2:0] move_y = '0;
  logic       nm_done, ack;
  logic [5:0] flip_count;

  move_flip_controller_if #(.BOARD_BITS(3)) bus ();

  move_flip_controller #(.BOARD_BITS(3)) dut (
    .clock(clock), .reset(reset), .new_move(new_move), .player(player),
    .move_x(move_x), .move_y(move_y), .nm_done(nm_done), .ack(ack),
    .flip_count(flip_count), .bus(bus)
  );

  always #5 clock = ~clock;

  logic [1:0] ram   [64];
  logic [1:0] board [64];
  logic       load_en = 1'b0;

  always @(posedge clock) begin
    if (load_en) begin
      for (int i = 0; i < 64; i++) ram[i] <= board[i];
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  int         obs_lat;

  function automatic bit on_board(input int x, input int y);
    return x >= 0 && x < 8 && y >= 0 && y < 8;
  endfunction

  // Reference: walk each ray on the pre-move board; rays never overlap.
  task automatic model_move(input logic p, input int mx, input int my);
    logic [1:0] own, opp;
    own = p ? 2'b10 : 2'b01;
    opp = p ? 2'b01 : 2'b10;
    exp_q.delete();
    if (board[my*8+mx] != 2'b00) return;
    for (int d = 0; d < 8; d++) begin
      int x, y, n;
      x = mx + DX[d];
      y = my + DY[d];
      n = 0;
      while (on_board(x, y) && board[y*8+x] == opp) begin
        n++;
        x += DX[d];
        y += DY[d];
      end
      if (n > 0 && on_board(x, y) && board[y*8+x] == own)
        for (int k = 1; k <= n; k++)
          exp_q.push_back({6'((my + k*DY[d])*8 + mx + k*DX[d]), own});
    end
    if (exp_q.size() > 0) exp_q.push_back({6'(my*8+mx), own});
  endtask

  task automatic load_ram();
    @(negedge clock);
    load_en = 1'b1;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic run_move(input logic p, input int x, input int y, input string tag);
    int         cyc, extra, exp_fc, bad;
    bit         done;
    logic       obs_ack;
    logic [5:0] obs_fc;
    logic [7:0] got_q [$];
    model_move(p, x, y);
    exp_fc = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
    @(negedge clock);
    player = p; move_x = 3'(x); move_y = 3'(y); new_move = 1'b1;
    cyc = 0; done = 0; obs_ack = 1'b0; obs_fc = '0;
    while (!done && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      player = 1'($urandom); move_x = 3'($urandom); move_y = 3'($urandom);
      if (bus.mem_we) got_q.push_back({bus.mem_addr, bus.mem_wdata});
      if (nm_done) begin
        done = 1; obs_ack = ack; obs_fc = flip_count; obs_lat = cyc;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(done), 1);
    check_eq({tag, "_ack"}, 32'(obs_ack), 32'(exp_q.size() > 0));
    check_eq({tag, "_flip_count"}, 32'(obs_fc), 32'(exp_fc));
    check_eq({tag, "_write_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_write%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (nm_done || bus.mem_we) extra++;
    end
    check_eq({tag, "_no_reaccept"}, 32'(extra), 0);
    new_move = 1'b0;
    @(negedge clock);
    check_eq({tag, "_fc_held"}, 32'(flip_count), 32'(exp_fc));
    foreach (exp_q[i]) board[exp_q[i][7:2]] = exp_q[i][1:0];
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== board[i]) bad++;
    check_eq({tag, "_board"}, 32'(bad), 0);
  endtask

  task automatic opening_board();
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    board[27] = 2'b10; board[36] = 2'b10;
    board[28] = 2'b01; board[35] = 2'b01;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    repeat (3) @(negedge clock);
    check_eq("rst_addr", 32'(bus.mem_addr), 0);
    check_eq("rst_we", 32'(bus.mem_we), 0);
    check_eq("rst_wdata", 32'(bus.mem_wdata), 0);
    check_eq("rst_done", 32'(nm_done), 0);
    check_eq("rst_ack", 32'(ack), 0);
    check_eq("rst_fc", 32'(flip_count), 0);
    reset = 1'b1;

    opening_board();
    load_ram();
    run_move(1'b0, 3, 2, "opening");

    opening_board();
    load_ram();
    run_move(1'b0, 3, 3, "occupied");
    check_eq("occupied_latency", 32'(obs_lat), 3);

    opening_board();
    load_ram();
    run_move(1'b0, 0, 0, "no_bracket");

    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    board[9] = 2'b10; board[18] = 2'b10; board[1] = 2'b10; board[8] = 2'b10;
    board[27] = 2'b01; board[2] = 2'b01; board[16] = 2'b01;
    load_ram();
    run_move(1'b0, 0, 0, "multi_dir");

    // Abort in the middle of the first flip, then redo the same move.
    opening_board();
    load_ram();
    @(negedge clock);
    player = 1'b0; move_x = 3'd3; move_y = 3'd2; new_move = 1'b1;
    wait_cyc = 0;
    while (!bus.mem_we && wait_cyc < 500) begin
      @(negedge clock);
      wait_cyc++;
    end
    check_eq("flip_reached", 32'(bus.mem_we), 1);
    #1;
    reset = 1'b0;
    new_move = 1'b0;
    #1;
    check_eq("midrst_we", 32'(bus.mem_we), 0);
    check_eq("midrst_addr", 32'(bus.mem_addr), 0);
    check_eq("midrst_wdata", 32'(bus.mem_wdata), 0);
    check_eq("midrst_done", 32'(nm_done), 0);
    check_eq("midrst_fc", 32'(flip_count), 0);
    @(negedge clock);
    reset = 1'b1;
    opening_board();
    load_ram();
    run_move(1'b0, 3, 2, "after_reset");

    for (int t = 0; t < 40; t++) begin
      int x, y, r;
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 9);
        board[i] = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      end
      x = $urandom_range(0, 7);
      y = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 8) board[y*8+x] = 2'b00;
      load_ram();
      run_move(1'($urandom), x, y, $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
